fpadd_pipe_fsm: RTL
===================

// Module: fpadd_pipe_fsm
// PURPOSE
// - Parametrised multi-cycle IEEE-754 floating-point adder/subtractor with a start/done handshake.
// - Generalises the single-precision adder to any EXP_W/MAN_W format. Adds subtract mode,
//   subnormal support, round-to-nearest-even and exception flags.
// - Sits between operand registers and the result bus of the FP datapath; one operation in flight.
// PARAMETERS
// - EXP_W  8   exponent field width (5 = half, 8 = single, 11 = double)
// - MAN_W  23  stored fraction width (hidden bit excluded)
// - W = 1+EXP_W+MAN_W (localparam), BIAS = 2**(EXP_W-1)-1 (localparam)
// PORTS
// - clk    in   1   rising-edge clock
// - reset  in   1   asynchronous, active-low reset (0 = reset)
// - start  in   1   operation request; sampled only in IDLE or DONE
// - a      in   W   operand A {sign, exp, frac}
// - b      in   W   operand B
// - sub    in   1   1: compute a-b (b sign inverted at capture); 0: a+b
// - sum    out  W   result; held stable while done=1
// - done   out  1   result valid; level, held until next accepted start
// - busy   out  1   1 in any state other than IDLE/DONE
// - flags  out  4   {invalid, overflow, underflow, inexact}; valid with done
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, sum=0, done=0, busy=0, flags=0; an op in flight is discarded.
// - FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE; UNPACK -> DONE on special operands.
// - Accepted start (IDLE/DONE), edge N: latch a, b^{sub<<(W-1)}; done<=0, flags<=0; goto UNPACK.
// - start while busy: ignored, operands unchanged. start in DONE: restart (done drops at edge N).
// - Latency: done rises at edge N+5 (normal path); at edge N+1 (special path).
// - UNPACK: exp==0 -> hidden bit 0, effective exp 1 (subnormal); else hidden bit 1.
// - Special operands, checked in priority order:
//   - Any NaN -> canonical qNaN (sign 0, exp all 1s, frac MSB 1, rest 0); invalid if any sNaN.
//   - inf + (-inf) -> qNaN, invalid=1.
//   - inf + x -> that inf; zero + x -> x unchanged.
//   - (+0)+(-0) -> +0; (-0)+(-0) -> -0.
// - ALIGN: swap so A has larger magnitude (exp, then frac).
//   - Shift smaller significand right by d = expA-expB into a MAN_W+4 bit field (sig, G, R, S).
//   - d saturates at MAN_W+3; bits shifted out OR into sticky.
// - ADD: signs equal -> add, else subtract (always non-negative after swap); MAN_W+5 bit result.
//   - Result sign = sign of A. Exact zero from cancellation -> +0.
// - NORM:
//   - Carry out -> shift right 1 (sticky kept), exp+1.
//   - Else left-shift by leading-zero count, limited so exp stays >= 1.
//   - exp=1 with hidden=0 -> subnormal result.
// - ROUND: RNE on G/R/S; inexact = G|R|S.
//   - Round carry renormalises (exp+1); subnormal rounding up to min-normal sets exp=1.
//   - exp >= 2**EXP_W-1 -> +/-inf, overflow=1, inexact=1.
//   - underflow = tiny result (subnormal or zero after rounding) AND inexact.
// - DONE: sum/flags registered at entry and held; busy=0.
// STRUCTURE
// - Shared package fp_pkg: FSM state encodings (3-bit), flag bit indices, default EXP_W/MAN_W,
//   qNaN constant function, special-class encodings (ZERO/SUB/NORM/INF/QNAN/SNAN).
// - One sub-module: fp_lzc (parametrised leading-zero counter, width MAN_W+5), used in NORM.
// - Alignment shifter, adder and rounder stay in this module, registered between FSM states.
// TESTING (single precision unless noted)
// - 0x3F800000 + 0x40000000, sub=0 -> sum 0x40400000, flags 0, done exactly 5 edges after start.
// - 0x3F800000 - 0x3F800000, sub=1 -> 0x00000000, flags 0; 0x80000000 + 0x80000000 -> 0x80000000.
// - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even), inexact=1.
//   0x3F800000 + 0x33800001 -> 0x3F800001, inexact=1.
// - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
//   0x00000001 + 0x00000001 -> 0x00000002, flags 0.
// - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1, done 1 edge after start.
//   0x7F800001 + 0x3F800000 -> 0x7FC00000, invalid=1.
// - Handshake/reset: start pulse while busy -> ignored, result of first op unchanged.
//   reset low in ALIGN -> sum=0, done=0, busy=0 immediately.
//   EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder: FSM states, flag positions,
// default format and operand class encodings.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_ALIGN  = 3'd2,
      ST_ADD    = 3'd3,
      ST_NORM   = 3'd4,
      ST_ROUND  = 3'd5,
      ST_DONE   = 3'd6
   } fsm_state_e;

   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } fp_class_e;

   // Canonical quiet NaN for an exp_w/man_w format, right-aligned in 64 bits.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
      v[man_w-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/fpadd_pipe_fsm_if.sv
// Start/done handshake and operand/result bus of the floating-point adder.
interface fpadd_pipe_fsm_if
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic [W-1:0] sum;
   logic         done;
   logic         busy;
   logic [3:0]   flags;

   modport master (output start, a, b, sub, input sum, done, busy, flags);
   modport slave  (input start, a, b, sub, output sum, done, busy, flags);

endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 28,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CW-1:0]    count_o
);

   always_comb begin
      count_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fpadd_pipe_fsm.sv
// Multi-cycle IEEE-754 adder/subtractor, one operation in flight, RNE rounding,
// subnormal support and exception flags.
module fpadd_pipe_fsm
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input logic             clk,
   input logic             reset,
   fpadd_pipe_fsm_if.slave bus
);

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int BIAS    = 2**(EXP_W-1) - 1;
   localparam int EXP_MAX = 2*BIAS + 1;
   localparam int SW      = MAN_W + 1;
   localparam int FW      = MAN_W + 4;
   localparam int AW      = MAN_W + 5;
   localparam int SH_MAX  = MAN_W + 3;
   localparam int LZW     = $clog2(AW + 1);
   localparam logic [63:0]  QNAN64 = fp_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0] QNAN   = QNAN64[W-1:0];

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0) return (f == '0) ? CLS_ZERO : CLS_SUB;
      if (e == {EXP_W{1'b1}}) begin
         if (f == '0) return CLS_INF;
         return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
      end
      return CLS_NORM;
   endfunction

   fsm_state_e       state_q, state_d;
   logic [W-1:0]     sum_q, sum_d;
   logic [3:0]       flags_q, flags_d;
   logic             accept;
   logic [W-1:0]     opa_q, opb_q;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   fp_class_e        ca, cb;
   logic             special_w, spec_inv_w;
   logic [W-1:0]     spec_sum_w;
   logic             sgn_a_q, sgn_b_q;
   logic [EXP_W-1:0] exp_a_q, exp_b_q;
   logic [SW-1:0]    sig_a_q, sig_b_q;

   logic             a_big;
   logic [EXP_W-1:0] exp_sml;
   logic [SW-1:0]    sig_sml;
   logic [FW-1:0]    sml_ext, lost;
   logic [31:0]      d_w;
   logic             sign_al_d, sign_al_q, eff_sub_d, eff_sub_q;
   logic [EXP_W-1:0] exp_al_d, exp_al_q;
   logic [FW-1:0]    big_d, big_q, sml_d, sml_q;

   logic             sign_ad_d, sign_ad_q;
   logic [EXP_W-1:0] exp_ad_q;
   logic [AW-1:0]    add_d, add_q;

   logic [LZW-1:0]   lz_w;
   logic [31:0]      sh_w, lim_w;
   logic [EXP_W:0]   nexp_d, nexp_q;
   logic [FW-1:0]    nsig_d, nsig_q;
   logic             sign_nm_q;

   logic [SW-1:0]    mant_w;
   logic             rup_w, hid_w, inexact_w;
   logic [SW:0]      mr_w;
   logic [MAN_W-1:0] frac_w;
   logic [EXP_W:0]   expf_w;
   logic [W-1:0]     rnd_sum_w;
   logic [3:0]       rnd_flags_w;

   assign bus.sum   = sum_q;
   assign bus.flags = flags_q;
   assign bus.done  = (state_q == ST_DONE);
   assign bus.busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);

   // UNPACK: classify operands and resolve special cases
   always_comb begin
      sa = opa_q[W-1];  ea = opa_q[W-2:MAN_W];  fa = opa_q[MAN_W-1:0];
      sb = opb_q[W-1];  eb = opb_q[W-2:MAN_W];  fb = opb_q[MAN_W-1:0];
      ca = classify(ea, fa);
      cb = classify(eb, fb);
      special_w  = 1'b1;
      spec_inv_w = 1'b0;
      spec_sum_w = QNAN;
      if (ca inside {CLS_QNAN, CLS_SNAN} || cb inside {CLS_QNAN, CLS_SNAN}) begin
         spec_inv_w = (ca == CLS_SNAN) || (cb == CLS_SNAN);
      end else if (ca == CLS_INF && cb == CLS_INF && sa != sb) begin
         spec_inv_w = 1'b1;
      end else if (ca == CLS_INF) begin
         spec_sum_w = opa_q;
      end else if (cb == CLS_INF) begin
         spec_sum_w = opb_q;
      end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
         spec_sum_w = {sa & sb, {(W-1){1'b0}}};
      end else if (ca == CLS_ZERO) begin
         spec_sum_w = opb_q;
      end else if (cb == CLS_ZERO) begin
         spec_sum_w = opa_q;
      end else begin
         special_w = 1'b0;
      end
   end

   // ALIGN: larger magnitude becomes A; smaller shifted right with sticky
   always_comb begin
      a_big     = (exp_a_q > exp_b_q) || (exp_a_q == exp_b_q && sig_a_q >= sig_b_q);
      sign_al_d = a_big ? sgn_a_q : sgn_b_q;
      exp_al_d  = a_big ? exp_a_q : exp_b_q;
      big_d     = {(a_big ? sig_a_q : sig_b_q), 3'b000};
      exp_sml   = a_big ? exp_b_q : exp_a_q;
      sig_sml   = a_big ? sig_b_q : sig_a_q;
      eff_sub_d = sgn_a_q ^ sgn_b_q;
      d_w = 32'(exp_al_d) - 32'(exp_sml);
      if (d_w > 32'(SH_MAX)) d_w = 32'(SH_MAX);
      sml_ext  = {sig_sml, 3'b000};
      lost     = sml_ext & ((FW'(1) << d_w) - FW'(1));
      sml_d    = sml_ext >> d_w;
      sml_d[0] = sml_d[0] | (|lost);
   end

   // ADD: magnitude add/subtract; exact cancellation yields +0
   always_comb begin
      add_d     = eff_sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
      sign_ad_d = (eff_sub_q && add_d == '0) ? 1'b0 : sign_al_q;
   end

   fp_lzc #(.WIDTH(AW), .CW(LZW)) u_lzc (.data_i(add_q), .count_o(lz_w));

   // NORM: bit AW-1 is the carry, bit AW-2 the hidden position
   always_comb begin
      sh_w  = 32'(lz_w) - 32'd1;
      lim_w = 32'(exp_ad_q) - 32'd1;
      if (add_q[AW-1]) begin
         nsig_d = {add_q[AW-1:2], |add_q[1:0]};
         nexp_d = {1'b0, exp_ad_q} + (EXP_W+1)'(1);
      end else begin
         if (sh_w > lim_w) sh_w = lim_w;
         nsig_d = FW'(add_q << sh_w);
         nexp_d = (EXP_W+1)'(32'(exp_ad_q) - sh_w);
      end
   end

   // ROUND: nearest-even on G/R/S, then overflow/underflow classification
   always_comb begin
      mant_w    = nsig_q[FW-1:3];
      inexact_w = |nsig_q[2:0];
      rup_w     = nsig_q[2] & (nsig_q[1] | nsig_q[0] | nsig_q[3]);
      mr_w      = {1'b0, mant_w} + (SW+1)'(rup_w);
      hid_w     = mr_w[SW] | mr_w[SW-1];
      frac_w    = mr_w[SW] ? mr_w[SW-1:1] : mr_w[SW-2:0];
      expf_w    = nexp_q + (EXP_W+1)'(mr_w[SW]);
      rnd_flags_w = '0;
      rnd_flags_w[FLG_INEXACT] = inexact_w;
      if (hid_w && expf_w >= (EXP_W+1)'(EXP_MAX)) begin
         rnd_sum_w = {sign_nm_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_flags_w[FLG_OVERFLOW] = 1'b1;
         rnd_flags_w[FLG_INEXACT]  = 1'b1;
      end else begin
         rnd_sum_w = {sign_nm_q, (hid_w ? expf_w[EXP_W-1:0] : {EXP_W{1'b0}}), frac_w};
         rnd_flags_w[FLG_UNDERFLOW] = ~hid_w & inexact_w;
      end
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      flags_d = flags_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               flags_d = '0;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            if (special_w) begin
               sum_d   = spec_sum_w;
               flags_d = '0;
               flags_d[FLG_INVALID] = spec_inv_w;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ALIGN;
            end
         end
         ST_ALIGN: state_d = ST_ADD;
         ST_ADD:   state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: begin
            sum_d   = rnd_sum_w;
            flags_d = rnd_flags_w;
            state_d = ST_DONE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sum_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         flags_q <= flags_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         opa_q <= bus.a;
         opb_q <= bus.b ^ {bus.sub, {(W-1){1'b0}}};
      end
      case (state_q)
         ST_UNPACK: begin
            sgn_a_q <= sa;
            sgn_b_q <= sb;
            exp_a_q <= (ea == '0) ? EXP_W'(1) : ea;
            exp_b_q <= (eb == '0) ? EXP_W'(1) : eb;
            sig_a_q <= {ea != '0, fa};
            sig_b_q <= {eb != '0, fb};
         end
         ST_ALIGN: begin
            sign_al_q <= sign_al_d;
            eff_sub_q <= eff_sub_d;
            exp_al_q  <= exp_al_d;
            big_q     <= big_d;
            sml_q     <= sml_d;
         end
         ST_ADD: begin
            sign_ad_q <= sign_ad_d;
            exp_ad_q  <= exp_al_q;
            add_q     <= add_d;
         end
         ST_NORM: begin
            sign_nm_q <= sign_ad_q;
            nexp_q    <= nexp_d;
            nsig_q    <= nsig_d;
         end
         default: ;
      endcase
   end

endmodule
